// File: rtl/blink_pkg.sv
// blink_pkg: shared definitions for the blink decoder.
//   - switch code constants (2-bit code carried by the blink rate)
//   - nominal half-periods in system clocks at 25 kHz, shared with led_blink
//   - decoder state enum
//   - window-match helper used by the classifier
package blink_pkg;

  localparam logic [1:0] CODE_100HZ = 2'b00;
  localparam logic [1:0] CODE_50HZ  = 2'b01;
  localparam logic [1:0] CODE_10HZ  = 2'b10;
  localparam logic [1:0] CODE_1HZ   = 2'b11;

  localparam int NOM_HALF_100HZ = 125;
  localparam int NOM_HALF_50HZ  = 250;
  localparam int NOM_HALF_10HZ  = 1250;
  localparam int NOM_HALF_1HZ   = 12500;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_MEASURE = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  // True when h lies within nom +/- tol (inclusive).
  function automatic logic in_window(input int h, input int nom, input int tol);
    return (h >= nom - tol) && (h <= nom + tol);
  endfunction

endpackage

// File: rtl/blink_edge_sync.sv
// blink_edge_sync: brings the asynchronous blink waveform into the clock
// domain and flags every transition of either polarity.
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   async_in   raw blink waveform
//   edge_pulse one-cycle registered pulse per input transition
// A transition sampled at clock k raises edge_pulse after clock k+2.
module blink_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      prev       <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync1      <= async_in;
      sync2      <= sync1;
      prev       <= sync2;
      edge_pulse <= sync2 ^ prev;
    end
  end

endmodule

// File: rtl/blink_decoder.sv
// blink_decoder: measures the half-period of an incoming blink waveform and
// recovers the 2-bit switch code that produced it.
//   i_clock      system clock, 25 kHz nominal
//   i_reset_n    asynchronous active-low reset
//   i_enable     decoder enable
//   i_led_drive  blink waveform, asynchronous to i_clock
//   o_switch_1   decoded code bit 1 (MSB)
//   o_switch_2   decoded code bit 0 (LSB)
//   o_valid      code locked and current
//   o_timeout    no edge seen for TIMEOUT clocks
//   o_period     last measured half-period in clocks
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | disabled; counters, lock and timeout cleared
// ST_ACQUIRE | waiting for the first edge, which only starts timing
// ST_MEASURE | classifying half-periods, counting consecutive matches
// ST_LOCKED  | code reported valid; any differing half-period drops lock
module blink_decoder
  import blink_pkg::*;
#(
  parameter int HALF_100HZ = NOM_HALF_100HZ,
  parameter int HALF_50HZ  = NOM_HALF_50HZ,
  parameter int HALF_10HZ  = NOM_HALF_10HZ,
  parameter int HALF_1HZ   = NOM_HALF_1HZ,
  parameter int TOL        = 8,
  parameter int LOCK_COUNT = 2,
  parameter int TIMEOUT    = 16384,
  parameter int CNT_W      = 15
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_led_drive,
  output logic             o_switch_1,
  output logic             o_switch_2,
  output logic             o_valid,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_period
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  // Windows must be ordered and disjoint, and the counter must hold TIMEOUT-1.
  if (!((HALF_100HZ + TOL < HALF_50HZ - TOL) &&
        (HALF_50HZ  + TOL < HALF_10HZ - TOL) &&
        (HALF_10HZ  + TOL < HALF_1HZ  - TOL))) begin : g_bad_windows
    $error("blink_decoder: classification windows overlap");
  end
  if ((TIMEOUT - 1) >= (2 ** CNT_W)) begin : g_bad_cnt_w
    $error("blink_decoder: CNT_W too small for TIMEOUT-1");
  end
  if (LOCK_COUNT < 1) begin : g_bad_lock
    $error("blink_decoder: LOCK_COUNT must be at least 1");
  end

  logic               edge_det;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [MATCH_W-1:0] match;
  logic [1:0]         prev_code;

  logic [CNT_W:0]     h;
  logic [CNT_W-1:0]   period_val;
  logic               hit;
  logic [1:0]         code;
  logic [MATCH_W-1:0] next_match;

  blink_edge_sync u_edge_sync (
    .clk        (i_clock),
    .rst_n      (i_reset_n),
    .async_in   (i_led_drive),
    .edge_pulse (edge_det)
  );

  // H = cnt+1 so that an ideal half-period of N clocks measures as N.
  // An edge landing on the timeout cycle gives H = TIMEOUT, which the
  // reported period clamps to the counter's saturation value.
  assign h          = {1'b0, cnt} + 1'b1;
  assign period_val = (h > {1'b0, CNT_MAX}) ? CNT_MAX : h[CNT_W-1:0];

  always_comb begin
    hit  = 1'b1;
    code = CODE_100HZ;
    if (in_window(int'(h), HALF_100HZ, TOL)) begin
      code = CODE_100HZ;
    end else if (in_window(int'(h), HALF_50HZ, TOL)) begin
      code = CODE_50HZ;
    end else if (in_window(int'(h), HALF_10HZ, TOL)) begin
      code = CODE_10HZ;
    end else if (in_window(int'(h), HALF_1HZ, TOL)) begin
      code = CODE_1HZ;
    end else begin
      hit = 1'b0;
    end
  end

  // Only consulted in ST_MEASURE, where match < LOCK_COUNT, so +1 cannot wrap.
  always_comb begin
    next_match = '0;
    if (hit) begin
      next_match = (code == prev_code) ? match + MATCH_W'(1) : MATCH_W'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      match      <= '0;
      prev_code  <= CODE_100HZ;
      o_switch_1 <= 1'b0;
      o_switch_2 <= 1'b0;
      o_valid    <= 1'b0;
      o_timeout  <= 1'b0;
      o_period   <= '0;
    end else if (!i_enable) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      match     <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (edge_det) begin
            cnt       <= '0;
            o_timeout <= 1'b0;
            state     <= ST_MEASURE;
          end
        end
        ST_MEASURE, ST_LOCKED: begin
          if (edge_det) begin
            cnt       <= '0;
            o_timeout <= 1'b0;
            o_period  <= period_val;
            if (state == ST_MEASURE) begin
              match <= next_match;
              if (hit) begin
                prev_code <= code;
              end
              if (hit && (next_match >= MATCH_W'(LOCK_COUNT))) begin
                o_switch_1 <= code[1];
                o_switch_2 <= code[0];
                o_valid    <= 1'b1;
                state      <= ST_LOCKED;
              end
            end else if (!(hit && (code == prev_code))) begin
              o_valid <= 1'b0;
              state   <= ST_MEASURE;
              if (hit) begin
                match     <= MATCH_W'(1);
                prev_code <= code;
              end else begin
                match <= '0;
              end
            end
          end else if (cnt == CNT_MAX) begin
            cnt       <= '0;
            match     <= '0;
            o_timeout <= 1'b1;
            o_valid   <= 1'b0;
            state     <= ST_ACQUIRE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blink_decoder.sv
// tb_blink_decoder: randomized and directed stimulus for blink_decoder,
// checked every cycle against an event-level reference model, plus literal
// expectations at the points where the behaviour is fixed by hand.
`timescale 1ns/1ps
module tb_blink_decoder;

  localparam int TOL        = 8;
  localparam int LOCK_COUNT = 2;
  localparam int TIMEOUT    = 16384;
  localparam int CNT_W      = 15;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             led;
  logic             sw1;
  logic             sw2;
  logic             valid;
  logic             tmo;
  logic [CNT_W-1:0] period;

  int n_checks = 0;
  int n_err    = 0;

  blink_decoder dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_enable    (enable),
    .i_led_drive (led),
    .o_switch_1  (sw1),
    .o_switch_2  (sw2),
    .o_valid     (valid),
    .o_timeout   (tmo),
    .o_period    (period)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Works on absolute clock numbers: an input change sampled at clock t is
  // acted on at clock t+3; a half-period is the distance between two such
  // event clocks; a timeout is TIMEOUT clocks since the last event.
  function automatic int nom(input int c);
    case (c)
      0:       return 125;
      1:       return 250;
      2:       return 1250;
      default: return 12500;
    endcase
  endfunction

  function automatic int classify(input int h);
    for (int c = 0; c < 4; c++) begin
      if (h >= nom(c) - TOL && h <= nom(c) + TOL) return c;
    end
    return -1;
  endfunction

  int hist[$];
  int m_t, m_mode, m_last, m_streak, m_code, m_sw, m_period, m_h, m_c;
  bit m_valid, m_tmo, m_ed;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist     = '{0, 0, 0, 0, 0};
      m_t      = 0;
      m_mode   = 0;
      m_last   = 0;
      m_streak = 0;
      m_code   = 0;
      m_sw     = 0;
      m_period = 0;
      m_valid  = 0;
      m_tmo    = 0;
    end else begin
      hist.push_back(int'(led));
      void'(hist.pop_front());
      m_ed = (hist[1] != hist[0]);
      if (!enable) begin
        m_mode   = 0;
        m_valid  = 0;
        m_tmo    = 0;
        m_streak = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (m_ed) begin
          m_tmo  = 0;
          m_last = m_t;
          m_mode = 2;
        end
      end else if (m_ed) begin
        m_h      = m_t - m_last;
        m_last   = m_t;
        m_tmo    = 0;
        m_period = (m_h > TIMEOUT - 1) ? TIMEOUT - 1 : m_h;
        m_c      = classify(m_h);
        if (m_mode == 2) begin
          if (m_c < 0) m_streak = 0;
          else if (m_c == m_code && m_streak > 0) m_streak++;
          else begin
            m_code   = m_c;
            m_streak = 1;
          end
          if (m_c >= 0 && m_streak >= LOCK_COUNT) begin
            m_sw    = m_c;
            m_valid = 1;
            m_mode  = 3;
          end
        end else if (m_c != m_code) begin
          m_valid = 0;
          m_mode  = 2;
          if (m_c < 0) m_streak = 0;
          else begin
            m_code   = m_c;
            m_streak = 1;
          end
        end
      end else if (m_t - m_last >= TIMEOUT) begin
        m_tmo    = 1;
        m_valid  = 0;
        m_mode   = 1;
        m_streak = 0;
      end
      m_t++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    n_checks++;
    if (valid !== m_valid || tmo !== m_tmo || {sw1, sw2} !== 2'(m_sw) ||
        period !== CNT_W'(m_period)) begin
      n_err++;
      $display("FAIL model_compare t=%0t: dut valid=%0b timeout=%0b code=%0d period=%0d, expected valid=%0b timeout=%0b code=%0d period=%0d",
               $time, valid, tmo, {sw1, sw2}, period, m_valid, m_tmo, m_sw, m_period);
    end
  end

  // ---------------- literal checks and stimulus ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
    led = ~led;
  endtask

  task automatic wave(input int half, input int count);
    for (int i = 0; i < count; i++) begin
      if (i > 0) repeat (half) @(negedge clk);
      led = ~led;
    end
  endtask

  // Restart from IDLE, three transitions at 'half', then the lock lands
  // exactly on the 4th falling edge after the last transition.
  task automatic lock_test(input int half, input int code);
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    wave(half, 3);
    repeat (3) @(negedge clk);
    check($sformatf("prelock_valid_%0d", half), int'(valid), 0);
    @(negedge clk);
    check($sformatf("lock_valid_%0d", half), int'(valid), 1);
    check($sformatf("lock_code_%0d", half), int'({sw1, sw2}), code);
    check($sformatf("lock_period_%0d", half), int'(period), half);
  endtask

  initial begin
    int half, n, j;
    rst_n  = 1'b0;
    enable = 1'b1;
    led    = 1'b0;

    repeat (20) begin
      @(negedge clk);
      led = ~led;
    end
    check("reset_valid", int'(valid), 0);
    check("reset_code", int'({sw1, sw2}), 0);
    check("reset_period", int'(period), 0);
    check("reset_timeout", int'(tmo), 0);

    @(negedge clk);
    enable = 1'b0;
    rst_n  = 1'b1;
    repeat (30) begin
      @(negedge clk);
      led = ~led;
    end
    check("idle_no_lock", int'(valid), 0);
    check("idle_period_hold", int'(period), 0);

    lock_test(125, 0);
    lock_test(250, 1);
    lock_test(1250, 2);

    // Code change while locked at 10: first 250 drops, second relocks to 01.
    gap(246);
    repeat (4) @(negedge clk);
    check("change_drop_valid", int'(valid), 0);
    check("change_period", int'(period), 250);
    gap(246);
    repeat (4) @(negedge clk);
    check("change_relock_valid", int'(valid), 1);
    check("change_relock_code", int'({sw1, sw2}), 1);

    // Tolerance edges.
    lock_test(133, 0);
    lock_test(117, 0);
    lock_test(242, 1);
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    wave(134, 4);
    repeat (4) @(negedge clk);
    check("miss_134_valid", int'(valid), 0);
    check("miss_134_period", int'(period), 134);

    // 1 Hz lock, then +/-1 clock jitter keeps the lock.
    lock_test(12500, 3);
    for (int i = 0; i < 2; i++) begin
      j = $urandom_range(0, 2);
      gap(12500 - 4 + j - 1);
      repeat (4) @(negedge clk);
      check("jitter_valid", int'(valid), 1);
      check("jitter_period", int'(period), 12500 + j - 1);
    end

    // Timeout: TIMEOUT clocks after the last edge.
    repeat (TIMEOUT - 1) @(negedge clk);
    check("pre_timeout_flag", int'(tmo), 0);
    check("pre_timeout_valid", int'(valid), 1);
    @(negedge clk);
    check("timeout_flag", int'(tmo), 1);
    check("timeout_valid", int'(valid), 0);
    check("timeout_code_hold", int'({sw1, sw2}), 3);

    // Resume: first edge clears timeout, two matches relock.
    gap(10);
    repeat (4) @(negedge clk);
    check("resume_timeout_clear", int'(tmo), 0);
    gap(121);
    gap(125);
    repeat (4) @(negedge clk);
    check("resume_relock_valid", int'(valid), 1);
    check("resume_relock_code", int'({sw1, sw2}), 0);

    // Randomized segments, covered by the per-cycle compare.
    for (int s = 0; s < 24; s++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        enable = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        enable = 1'b1;
      end
      case ($urandom_range(0, 2))
        0:       half = 125 + $urandom_range(0, 24) - 12;
        1:       half = 250 + $urandom_range(0, 24) - 12;
        default: half = $urandom_range(20, 400);
      endcase
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) gap(half);
    end

    // Enable drop while locked: o_valid falls on the next clock.
    lock_test(125, 0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("disable_valid", int'(valid), 0);
    check("disable_code_hold", int'({sw1, sw2}), 0);
    check("disable_period_hold", int'(period), 125);
    enable = 1'b1;

    // Asynchronous reset between clock edges while locked.
    lock_test(250, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", int'(valid), 0);
    check("async_reset_code", int'({sw1, sw2}), 0);
    check("async_reset_period", int'(period), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_valid", int'(valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/blink_decoder.md
Name: blink_decoder

Overview:
- Receive-side counterpart to led_blink: measures an incoming blink waveform and recovers the 2-bit switch code that produced it.
- Code map: 00=100 Hz, 01=50 Hz, 10=10 Hz, 11=1 Hz, at the 25 kHz system clock.
- Sits on a loopback or monitoring path so a board self-test can confirm the LED driver output from the switch setting.
- Reports code, measured half-period, valid lock and timeout.

Parameters:
- HALF_100HZ, 125, half-period in clocks for code 00
- HALF_50HZ, 250, half-period in clocks for code 01
- HALF_10HZ, 1250, half-period in clocks for code 10
- HALF_1HZ, 12500, half-period in clocks for code 11
- TOL, 8, accepted deviation (+/- clocks) around each nominal
- LOCK_COUNT, 2, consecutive matching half-periods required to assert valid
- TIMEOUT, 16384, clocks without an edge before timeout
- CNT_W, 15, counter and o_period width; must hold TIMEOUT-1

Ports:
- i_clock  in  1  system clock, 25 kHz nominal
- i_reset_n  in  1  asynchronous active-low reset
- i_enable  in  1  decoder enable
- i_led_drive  in  1  blink waveform, asynchronous to i_clock
- o_switch_1  out  1  decoded code bit 1 (MSB)
- o_switch_2  out  1  decoded code bit 0 (LSB)
- o_valid  out  1  code locked and current
- o_timeout  out  1  no edge seen for TIMEOUT clocks
- o_period  out  CNT_W  last measured half-period in clocks

Behaviour:
- Clocking and reset:
  - One clock: i_clock.
  - i_reset_n is asynchronous assert, synchronous deassert at the board level.
  - Reset sets all outputs, counters, sync flops and state to 0/IDLE.
- Input path:
  - 2-FF synchronizer on i_led_drive, then a previous-value register.
  - edge = sync2 XOR prev (either polarity).
- Half-period counter cnt:
  - Cleared to 0 on edge; otherwise increments each cycle in MEASURE/LOCKED.
  - Saturates at TIMEOUT-1.
  - Measured half-period on edge: H = cnt+1, so an ideal square wave with half-period N clocks gives H=N.
- Classification: H is assigned a code if |H - HALF_x| <= TOL; otherwise it is a miss. Windows must not overlap (parameter check at elaboration).
- States: IDLE, ACQUIRE, MEASURE, LOCKED.
  - IDLE: entered on reset or i_enable=0. cnt, match and o_valid/o_timeout cleared; o_switch_* and o_period hold. On i_enable=1 -> ACQUIRE.
  - ACQUIRE: waits for the first edge, which only starts timing (no classification) -> MEASURE.
  - MEASURE: on edge, latch o_period=H, then:
    - If H is classified and equals the previous code, match++.
    - If H is classified with a new code, match=1 and the previous code is updated.
    - If H is a miss, match=0.
    - When match reaches LOCK_COUNT: o_switch_* = code, o_valid=1, -> LOCKED.
  - LOCKED: on edge, latch o_period, then:
    - Same code: stay.
    - Different valid code: o_valid=0, match=1 with the new code, -> MEASURE.
    - Miss: o_valid=0, match=0, -> MEASURE.
- Timeout:
  - In MEASURE/LOCKED, cnt reaching TIMEOUT-1 with no edge sets o_timeout=1 and o_valid=0, and goes to ACQUIRE.
  - o_switch_* hold their last value.
  - o_timeout clears on the next edge.
- Latency:
  - Input transition sampled at clock k: edge is seen in cycle k+2; outputs update at clock k+3.
  - With ideal input, o_valid rises 3 clocks after the third transition.
- Simultaneous events:
  - i_enable falling has priority over edge and timeout.
  - An edge in the same cycle cnt hits TIMEOUT-1 counts as an edge, not a timeout.
- Reset mid-operation: immediate return to all-zero, IDLE; no partial state survives.
- Outputs are registered; no combinational path from any input to any output.

Decomposition:
- Package blink_pkg holds:
  - code constants CODE_100HZ..CODE_1HZ
  - nominal half-period constants, shared with led_blink
  - state enum
- One natural sub-module: blink_edge_sync (2-FF synchronizer plus edge detect, async active-low reset). Classifier and FSM stay in blink_decoder.

Test Plan:
- Reset/idle: hold i_reset_n=0 with i_enable=1 and toggling input -> all outputs 0. Release with i_enable=0 -> stays IDLE, no lock.
- 100 Hz lock: toggle every 125 clocks -> o_period=125, o_valid=1, switches=00 exactly 3 clocks after the 3rd transition. Repeat for 250/1250/12500 -> codes 01/10/11.
- Tolerance: half-periods 133 and 117 -> lock to 00. 134 -> miss, o_valid stays 0. Jitter of +/-1 clock at 1 Hz -> lock holds.
- Code change: locked at 10, switch to 250-clock half-periods -> o_valid drops on the first 250 measurement and relocks to 01 on the second.
- Timeout: stop toggling while locked at 11 -> o_timeout=1, o_valid=0 after 16384 idle clocks, switches hold 11. Resume toggling -> o_timeout clears on the first edge, relock after LOCK_COUNT matches.
- Mid-operation: deassert i_enable while locked -> o_valid=0 next clock. Assert i_reset_n=0 asynchronously between clock edges -> outputs 0 immediately, without waiting for a clock.
